// File: rtl/adc_scan_sequencer.sv
// Channel-mask scan sequencer for an ADC0808/0809: select, ALE/SC pulse, EOC handshake, OE read, per-channel bank.
// Optional macro ADC_EOC_SYNC_EN adds a 2-flop synchronizer on eoc.
module adc_scan_sequencer #(
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int OE_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] ch_mask,
  input  logic       err_clr,
  input  logic       eoc,
  input  logic [7:0] adc_data,
  output logic [2:0] sel,
  output logic       ale,
  output logic       sc,
  output logic       oe,
  output logic       busy,
  output logic       sample_valid,
  output logic [2:0] sample_ch,
  output logic [7:0] sample_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       timeout_err
);

  localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_B = (OE_CYCLES > TIMEOUT_CYCLES) ? OE_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, START, WAIT_LOW, WAIT_HIGH, READ, STORE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ptr;
  logic [7:0]       bank [8];
  logic             eoc_fsm;
  logic [2:0]       next_ch;
  logic [2:0]       idx;
  logic             found;

`ifdef ADC_EOC_SYNC_EN
  logic [1:0] eoc_sync;

  // Resets high so an idle (high) EOC line is not mistaken for a conversion in progress
  always_ff @(posedge clk_in) begin
    if (rst) eoc_sync <= 2'b11;
    else     eoc_sync <= {eoc_sync[0], eoc};
  end
  assign eoc_fsm = eoc_sync[1];
`else
  assign eoc_fsm = eoc;
`endif

  // Round-robin pick: first enabled channel at or above ptr, wrapping 7 -> 0
  always_comb begin
    next_ch = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && ch_mask[idx]) begin
        found   = 1'b1;
        next_ch = idx;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ptr          <= '0;
      sel          <= '0;
      ale          <= 1'b0;
      sc           <= 1'b0;
      oe           <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      rd_data      <= '0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < 8; i++) bank[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      rd_data      <= bank[rd_addr];
      // A timeout assigned later in this block overrides the clear
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (enable && (ch_mask != 8'h00)) begin
            sel   <= next_ch;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt   <= '0;
            ale   <= 1'b1;
            sc    <= 1'b1;
            state <= START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        START: begin
          if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
            cnt   <= '0;
            ale   <= 1'b0;
            sc    <= 1'b0;
            state <= WAIT_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!eoc_fsm) begin
            cnt   <= '0;
            state <= WAIT_HIGH;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            ptr         <= sel + 3'd1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (eoc_fsm) begin
            cnt   <= '0;
            oe    <= 1'b1;
            state <= READ;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt         <= '0;
            timeout_err <= 1'b1;
            ptr         <= sel + 3'd1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          // Bank is written on the edge entering STORE so a same-address read sees old data for one cycle
          if (cnt == CNT_W'(OE_CYCLES - 1)) begin
            cnt          <= '0;
            oe           <= 1'b0;
            sample_valid <= 1'b1;
            sample_ch    <= sel;
            sample_data  <= adc_data;
            bank[sel]    <= adc_data;
            ptr          <= sel + 3'd1;
            state        <= STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STORE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Control stage directly upstream of the ADC interface.
- Scans the 8-channel ADC0808/0809 mux with a channel mask. For each enabled channel it drives select lines, ALE and start-conversion, waits for EOC, then pulses OE and captures the data.
- Delivers tagged samples downstream and keeps a readable bank of the latest value per channel.

Parameters:
SETUP_CYCLES, 2, cycles sel is held stable before ALE/SC rise (min 1)
PULSE_CYCLES, 4, width of the ALE/SC pulse in cycles (min 1)
OE_CYCLES, 4, cycles OE is held high before data capture (min 1)
TIMEOUT_CYCLES, 4096, max cycles spent waiting in each EOC wait state

Ports:
clk_in  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  scanning runs while high
ch_mask  in  8  bit n=1 means channel n is scanned
err_clr  in  1  clears timeout_err
eoc  in  1  end of conversion from ADC
adc_data  in  8  ADC output bus
sel  out  3  channel select; sel[0]=a, sel[1]=b, sel[2]=c
ale  out  1  address latch enable
sc  out  1  start conversion
oe  out  1  output enable to ADC
busy  out  1  high in every state except IDLE
sample_valid  out  1  one-cycle pulse per captured sample
sample_ch  out  3  channel of the current sample
sample_data  out  8  captured data
rd_addr  in  3  bank read address
rd_data  out  8  bank[rd_addr], registered, 1-cycle latency
timeout_err  out  1  sticky EOC timeout flag

Behaviour:
- Reset: the following take effect at the next edge with rst=1.
  - All outputs 0; state IDLE; channel pointer ptr=0.
  - All 8 bank entries 0; timers 0.
  - Reset mid-conversion aborts it with no sample_valid and no bank write.
- All outputs are registered.
- FSM states: IDLE, SETUP, START, WAIT_LOW, WAIT_HIGH, READ, STORE.
- IDLE:
  - If enable=1 and ch_mask!=0, select ch = first set mask bit searching from ptr upward, wrapping 7→0.
  - sel<=ch and go to SETUP. Otherwise stay in IDLE.
  - ch_mask is sampled only in IDLE.
- SETUP: hold for SETUP_CYCLES, then go to START.
- START: ale=sc=1 for exactly PULSE_CYCLES, then both 0 and go to WAIT_LOW.
- WAIT_LOW: wait for eoc=0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for eoc=1, then go to READ.
- READ:
  - oe=1 for OE_CYCLES.
  - adc_data is captured at the edge ending the last OE cycle.
  - oe falls when the FSM enters STORE.
- STORE (1 cycle):
  - sample_valid=1, sample_ch=ch, sample_data=captured value.
  - bank[ch] written.
  - ptr<=(ch+1) mod 8.
  - Go to IDLE.
- Latency: enable sampled high in IDLE at edge k gives:
  - sel valid from k+1;
  - ale/sc high from k+1+SETUP_CYCLES for PULSE_CYCLES cycles.
- Steady-state scan with an instant-responding ADC returns to IDLE once per channel. IDLE costs 1 cycle per sample.
- Timeout:
  - A separate counter in each of WAIT_LOW and WAIT_HIGH; it resets on entering each state.
  - After TIMEOUT_CYCLES cycles in one of them: timeout_err<=1, no sample_valid, no bank write, oe stays 0, ptr<=(ch+1) mod 8, go to IDLE.
- err_clr=1 clears timeout_err. A timeout in the same cycle wins: flag is set.
- enable deasserted mid-conversion: the conversion completes through STORE, then the FSM stays in IDLE.
- Single-bit mask: the same channel is converted repeatedly.
- Mask changed during a conversion: takes effect at the next IDLE.
- sel is held constant from SETUP through STORE.
- Bank read:
  - rd_data updates every cycle from rd_addr.
  - If rd_addr equals the channel being written in STORE, rd_data returns the old value that cycle and the new value on the next cycle.

Optional Feature:
- Macro ADC_EOC_SYNC_EN.
- Defined:
  - eoc passes through a 2-flop synchronizer (reset to 1) before the FSM.
  - EOC-driven transitions occur 2 cycles later than without the macro.
  - Timeout counting is unchanged.
- Undefined: eoc is used directly. The source must be synchronous to clk_in.

Test Plan:
- Basic scan: rst then enable=1, ch_mask=8'h01, ADC model drops eoc 3 cycles after sc falls, raises it 10 cycles later, adc_data=8'hA5.
  - Required: sel=0; ale/sc high 4 cycles starting 3 cycles after enable; oe high 4 cycles; sample_valid with ch=0, data=A5; rd_addr=0 gives A5.
- Mask wrap: ch_mask=8'b1000_0010, model returns data = 8'h10+ch.
  - Required: sample_ch sequence 1,7,1,7; sample_data 11,17,11,17.
- Timeout: model never drops eoc, TIMEOUT_CYCLES=16.
  - Required: no sample_valid; timeout_err=1 after 16 WAIT_LOW cycles; ptr advances; err_clr clears the flag.
- Enable drop: deassert enable during WAIT_HIGH.
  - Required: the sample still completes with one sample_valid; then busy=0 and the FSM stays in IDLE.
- Reset mid-READ with oe=1: assert rst.
  - Required: next cycle oe=0, busy=0, bank all 0, no sample_valid.
- ADC_EOC_SYNC_EN defined, basic scan repeated.
  - Required: oe rises 2 cycles later than in the undefined build; data identical.
